// File: rtl/mmio_pkg.sv
// ============================================================================
// mmio_pkg : register map, access-size encoding and lane helpers for mmio_unit
// Revision : 1.0
// ============================================================================
`default_nettype none

package mmio_pkg;

   localparam logic [31:0] c_DEFAULT_BASE = 32'h0000_7000;

   localparam logic [11:0] c_OFF_LEDR  = 12'h000;
   localparam logic [11:0] c_OFF_LEDG  = 12'h010;
   localparam logic [11:0] c_OFF_HEX03 = 12'h020;
   localparam logic [11:0] c_OFF_HEX47 = 12'h024;
   localparam logic [11:0] c_OFF_LCD   = 12'h030;
   localparam logic [11:0] c_OFF_SW    = 12'h800;
   localparam logic [11:0] c_OFF_BTN   = 12'h810;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_e;

   // Select the addressed byte/half of a word and extend it to 32 bits.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  lo,
                                               input logic [2:0]  f3);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {lo, 3'b000};
      case (f3)
         F3_B:    res = {{24{sh[7]}}, sh[7:0]};
         F3_BU:   res = {24'd0, sh[7:0]};
         F3_H:    res = {{16{sh[15]}}, sh[15:0]};
         F3_HU:   res = {16'd0, sh[15:0]};
         default: res = sh;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [3:0]  be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// btn_debounce : 2-flop synchronizer for one button, plus a stability counter
//                when MMIO_DEBOUNCE_EN is defined (otherwise sync only).
// Revision     : 1.0
// ============================================================================
`default_nettype none

module btn_debounce
`ifdef MMIO_DEBOUNCE_EN
#(
   parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_btn
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_btn;
         r_s2 <= r_s1;
      end
   end

`ifdef MMIO_DEBOUNCE_EN
   localparam int              c_CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

   logic [c_CW-1:0] r_cnt;
   logic            r_deb;

   // Any cycle where the input agrees with the debounced value restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
         r_deb <= 1'b0;
      end else if (r_s2 == r_deb) begin
         r_cnt <= '0;
      end else if (r_cnt == c_LAST) begin
         r_cnt <= '0;
         r_deb <= ~r_deb;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_btn = r_deb;
`else
   assign o_btn = r_s2;
`endif

endmodule

`default_nettype wire

// File: rtl/mmio_unit.sv
// ============================================================================
// mmio_unit : memory-mapped LED/HEX/LCD outputs and SW/BTN inputs with a
//             one-cycle load response. Optional button debounce via
//             MMIO_DEBOUNCE_EN.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module mmio_unit
   import mmio_pkg::*;
#(
   parameter int          DEBOUNCE_CYCLES = 16,
   parameter logic [31:0] BASE            = c_DEFAULT_BASE
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic        i_ld,
   input  logic        i_st,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_io_sw,
   input  logic [3:0]  i_io_btn,
   output logic [31:0] o_rdata,
   output logic        o_rvalid,
   output logic        o_err,
   output logic [31:0] o_io_ledr,
   output logic [31:0] o_io_ledg,
   output logic [31:0] o_io_lcd,
   output logic [6:0]  o_io_hex0,
   output logic [6:0]  o_io_hex1,
   output logic [6:0]  o_io_hex2,
   output logic [6:0]  o_io_hex3,
   output logic [6:0]  o_io_hex4,
   output logic [6:0]  o_io_hex5,
   output logic [6:0]  o_io_hex6,
   output logic [6:0]  o_io_hex7
);

   logic [31:0] r_ledr;
   logic [31:0] r_ledg;
   logic [31:0] r_lcd;
   logic [6:0]  r_hex [8];
   logic [31:0] r_sw_s1;
   logic [31:0] r_sw_s2;
   logic [31:0] r_rdata;
   logic        r_rvalid;
   logic        r_err;

   logic [3:0]  w_btn;
   logic [31:0] w_off;
   logic [11:0] w_word;
   logic        w_in_win;
   logic        w_ld;
   logic        w_req;
   logic        w_misal;
   logic        w_mapped;
   logic        w_ro;
   logic        w_bad;
   logic        w_wr;
   logic [3:0]  w_be;
   logic [31:0] w_rd_word;
   logic [31:0] w_wdata_sh;

   generate
      for (genvar g = 0; g < 4; g++) begin : g_btn
         btn_debounce
`ifdef MMIO_DEBOUNCE_EN
            #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
         u_btn (
            .clk   (clk),
            .reset (reset),
            .i_btn (i_io_btn[g]),
            .o_btn (w_btn[g])
         );
      end
   endgenerate

   // Window membership by offset so BASE need not be 4 KiB aligned.
   assign w_off      = i_addr - BASE;
   assign w_in_win   = (w_off[31:12] == 20'd0);
   assign w_word     = {w_off[11:2], 2'b00};
   assign w_ld       = i_ld & ~i_st;
   assign w_req      = (w_ld | i_st) & w_in_win;
   assign w_wdata_sh = i_wdata << {w_off[1:0], 3'b000};

   always_comb begin
      w_misal = 1'b0;
      w_be    = 4'b0000;
      case (i_funct3)
         F3_B, F3_BU: w_be = 4'b0001 << w_off[1:0];
         F3_H, F3_HU: begin
            w_misal = w_off[0];
            w_be    = 4'b0011 << w_off[1:0];
         end
         F3_W: begin
            w_misal = |w_off[1:0];
            w_be    = 4'b1111;
         end
         default: w_misal = 1'b1;
      endcase
   end

   always_comb begin
      w_mapped  = 1'b1;
      w_ro      = 1'b0;
      w_rd_word = 32'd0;
      case (w_word)
         c_OFF_LEDR:  w_rd_word = r_ledr;
         c_OFF_LEDG:  w_rd_word = r_ledg;
         c_OFF_HEX03: w_rd_word = {1'b0, r_hex[3], 1'b0, r_hex[2], 1'b0, r_hex[1], 1'b0, r_hex[0]};
         c_OFF_HEX47: w_rd_word = {1'b0, r_hex[7], 1'b0, r_hex[6], 1'b0, r_hex[5], 1'b0, r_hex[4]};
         c_OFF_LCD:   w_rd_word = r_lcd;
         c_OFF_SW: begin
            w_ro      = 1'b1;
            w_rd_word = r_sw_s2;
         end
         c_OFF_BTN: begin
            w_ro      = 1'b1;
            w_rd_word = {28'd0, w_btn};
         end
         default: w_mapped = 1'b0;
      endcase
   end

   assign w_bad = w_misal | ~w_mapped | (i_st & w_ro);
   assign w_wr  = w_req & i_st & ~w_bad;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ledr   <= '0;
         r_ledg   <= '0;
         r_lcd    <= '0;
         r_sw_s1  <= '0;
         r_sw_s2  <= '0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            r_hex[i] <= '0;
         end
      end else begin
         r_sw_s1  <= i_io_sw;
         r_sw_s2  <= r_sw_s1;
         r_rvalid <= w_req & w_ld;
         r_err    <= w_req & w_bad;
         r_rdata  <= (w_req & w_ld & ~w_bad) ? load_extend(w_rd_word, w_off[1:0], i_funct3) : 32'd0;
         if (w_wr) begin
            case (w_word)
               c_OFF_LEDR: r_ledr <= lane_merge(r_ledr, w_wdata_sh, w_be);
               c_OFF_LEDG: r_ledg <= lane_merge(r_ledg, w_wdata_sh, w_be);
               c_OFF_LCD:  r_lcd  <= lane_merge(r_lcd,  w_wdata_sh, w_be);
               c_OFF_HEX03: begin
                  for (int i = 0; i < 4; i++) begin
                     if (w_be[i]) r_hex[i] <= w_wdata_sh[8*i +: 7];
                  end
               end
               c_OFF_HEX47: begin
                  for (int i = 0; i < 4; i++) begin
                     if (w_be[i]) r_hex[i+4] <= w_wdata_sh[8*i +: 7];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_rdata   = r_rdata;
   assign o_rvalid  = r_rvalid;
   assign o_err     = r_err;
   assign o_io_ledr = r_ledr;
   assign o_io_ledg = r_ledg;
   assign o_io_lcd  = r_lcd;
   assign o_io_hex0 = r_hex[0];
   assign o_io_hex1 = r_hex[1];
   assign o_io_hex2 = r_hex[2];
   assign o_io_hex3 = r_hex[3];
   assign o_io_hex4 = r_hex[4];
   assign o_io_hex5 = r_hex[5];
   assign o_io_hex6 = r_hex[6];
   assign o_io_hex7 = r_hex[7];

endmodule

`default_nettype wire

// File: tb/tb_mmio_unit.sv
// ============================================================================
// tb_mmio_unit : directed scoreboard bench for mmio_unit
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_mmio_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic        i_ld;
   logic        i_st;
   logic [2:0]  i_funct3;
   logic [31:0] i_io_sw;
   logic [3:0]  i_io_btn;
   logic [31:0] o_rdata;
   logic        o_rvalid;
   logic        o_err;
   logic [31:0] o_io_ledr;
   logic [31:0] o_io_ledg;
   logic [31:0] o_io_lcd;
   logic [6:0]  o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3;
   logic [6:0]  o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7;

   mmio_unit #(.DEBOUNCE_CYCLES(16), .BASE(32'h0000_7000)) dut (
      .clk       (clk),
      .reset     (reset),
      .i_addr    (i_addr),
      .i_wdata   (i_wdata),
      .i_ld      (i_ld),
      .i_st      (i_st),
      .i_funct3  (i_funct3),
      .i_io_sw   (i_io_sw),
      .i_io_btn  (i_io_btn),
      .o_rdata   (o_rdata),
      .o_rvalid  (o_rvalid),
      .o_err     (o_err),
      .o_io_ledr (o_io_ledr),
      .o_io_ledg (o_io_ledg),
      .o_io_lcd  (o_io_lcd),
      .o_io_hex0 (o_io_hex0),
      .o_io_hex1 (o_io_hex1),
      .o_io_hex2 (o_io_hex2),
      .o_io_hex3 (o_io_hex3),
      .o_io_hex4 (o_io_hex4),
      .o_io_hex5 (o_io_hex5),
      .o_io_hex6 (o_io_hex6),
      .o_io_hex7 (o_io_hex7)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        valid;
      logic        err;
      int          cyc;
      string       name;
   } exp_t;

   exp_t expq[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every response the DUT presents must match the oldest expectation.
   always @(negedge clk) begin
      if (o_rvalid === 1'b1 || o_err === 1'b1) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: got rvalid=%0b err=%0b rdata=0x%08h, expected none",
                     o_rvalid, o_err, o_rdata);
         end else begin
            exp_t e;
            e = expq.pop_front();
            if (o_rvalid !== e.valid || o_err !== e.err || o_rdata !== e.rdata || cyc != e.cyc) begin
               errors++;
               $display("FAIL %s: got rvalid=%0b err=%0b rdata=0x%08h cyc=%0d, expected rvalid=%0b err=%0b rdata=0x%08h cyc=%0d",
                        e.name, o_rvalid, o_err, o_rdata, cyc, e.valid, e.err, e.rdata, e.cyc);
            end
         end
      end
   end

   // Called at a negedge; leaves the bus idle at the following negedge.
   task automatic req(input bit ld, input bit st, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3, input string name,
                      input bit ev, input bit ee, input logic [31:0] ed);
      exp_t e;
      i_ld = ld; i_st = st; i_addr = addr; i_wdata = wdata; i_funct3 = f3;
      if (ev || ee) begin
         e.rdata = ed; e.valid = ev; e.err = ee; e.cyc = cyc + 1; e.name = name;
         expq.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      i_ld = 1'b0; i_st = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      i_addr = 32'h7000; i_wdata = 32'h0; i_funct3 = W;
      i_ld = 1'b1; i_st = 1'b0;   // request held during reset must be dropped
      i_io_sw = 32'h0; i_io_btn = 4'h0;
      repeat (3) @(negedge clk);
      i_ld = 1'b0;
      reset = 1'b0;
      chk("rst_ledr", o_io_ledr, 32'h0);
      chk("rst_ledg", o_io_ledg, 32'h0);
      chk("rst_lcd",  o_io_lcd,  32'h0);
      chk("rst_hex",  {o_io_hex7, o_io_hex6, o_io_hex5, o_io_hex4, o_io_hex3, o_io_hex2, o_io_hex1, o_io_hex0}, 56'h0);
      chk("rst_resp", {o_rdata[29:0], o_rvalid, o_err}, 32'h0);

      req(1, 0, 32'h7000, 32'h0, W, "ld_ledr_rst", 1, 0, 32'h0);

      req(0, 1, 32'h7000, 32'hDEADBEEF, W, "st_ledr_w", 0, 0, 32'h0);
      chk("ledr_word", o_io_ledr, 32'hDEADBEEF);
      req(0, 1, 32'h7001, 32'h00000012, B, "st_ledr_b1", 0, 0, 32'h0);
      req(1, 0, 32'h7000, 32'h0, W, "ld_ledr_merged", 1, 0, 32'hDEAD12EF);
      req(1, 0, 32'h7002, 32'h0, H,  "ld_h_signed",   1, 0, 32'hFFFFDEAD);
      req(1, 0, 32'h7002, 32'h0, HU, "ld_h_unsigned", 1, 0, 32'h0000DEAD);
      req(1, 0, 32'h7003, 32'h0, B,  "ld_b_signed",   1, 0, 32'hFFFFFFDE);
      req(1, 0, 32'h7003, 32'h0, BU, "ld_b_unsigned", 1, 0, 32'h000000DE);

      req(0, 1, 32'h7020, 32'h7F3F0679, W, "st_hex03", 0, 0, 32'h0);
      chk("hex0", {25'd0, o_io_hex0}, 32'h79);
      chk("hex1", {25'd0, o_io_hex1}, 32'h06);
      chk("hex2", {25'd0, o_io_hex2}, 32'h3F);
      chk("hex3", {25'd0, o_io_hex3}, 32'h7F);
      req(1, 0, 32'h7023, 32'h0, B, "ld_hex3_b", 1, 0, 32'h0000007F);
      req(0, 1, 32'h7025, 32'h000000FF, B, "st_hex5_b", 0, 0, 32'h0);
      chk("hex5_bit7_drop", {25'd0, o_io_hex5}, 32'h7F);
      req(1, 0, 32'h7024, 32'h0, W, "ld_hex47", 1, 0, 32'h00007F00);

      req(0, 1, 32'h7002, 32'h11111111, W, "st_misaligned", 0, 1, 32'h0);
      chk("ledr_after_misal", o_io_ledr, 32'hDEAD12EF);
      req(1, 0, 32'h7004, 32'h0, W, "ld_unmapped", 1, 1, 32'h0);
      req(1, 0, 32'h7001, 32'h0, H, "ld_h_misal", 1, 1, 32'h0);
      req(0, 1, 32'h7040, 32'h5, W, "st_unmapped", 0, 1, 32'h0);

      req(0, 1, 32'h7012, 32'h0000BEEF, H, "st_ledg_h", 0, 0, 32'h0);
      chk("ledg_half", o_io_ledg, 32'hBEEF0000);

      req(1, 1, 32'h7030, 32'h12345678, W, "ld_st_same", 0, 0, 32'h0);
      chk("lcd_ldst", o_io_lcd, 32'h12345678);

      req(0, 1, 32'h8000, 32'hFFFFFFFF, W, "st_outside", 0, 0, 32'h0);
      req(1, 0, 32'h6FFC, 32'h0, W, "ld_outside", 0, 0, 32'h0);
      chk("ledr_after_outside", o_io_ledr, 32'hDEAD12EF);

      i_io_sw = 32'h0000ABCD;
      repeat (2) @(negedge clk);
      req(1, 0, 32'h7800, 32'h0, W, "ld_sw", 1, 0, 32'h0000ABCD);
      req(0, 1, 32'h7800, 32'h1, W, "st_sw", 0, 1, 32'h0);

`ifdef MMIO_DEBOUNCE_EN
      i_io_btn = 4'h1;
      repeat (5) @(negedge clk);
      i_io_btn = 4'h0;
      repeat (20) @(negedge clk);
      req(1, 0, 32'h7810, 32'h0, W, "ld_btn_glitch", 1, 0, 32'h0);
      i_io_btn = 4'h1;
      repeat (20) @(negedge clk);
      req(1, 0, 32'h7810, 32'h0, W, "ld_btn_held", 1, 0, 32'h1);
`else
      i_io_btn = 4'hA;
      repeat (2) @(negedge clk);
      req(1, 0, 32'h7810, 32'h0, W, "ld_btn_sync", 1, 0, 32'h0000000A);
`endif

      // A request coinciding with reset produces no response and clears state.
      reset = 1'b1;
      i_ld = 1'b1; i_addr = 32'h7000; i_funct3 = W;
      @(negedge clk);
      i_ld = 1'b0;
      reset = 1'b0;
      chk("ledr_reset_again", o_io_ledr, 32'h0);

      repeat (3) @(negedge clk);
      chk("queue_drained", expq.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
